// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU front end: datapath width, fetch FSM
// states and reset constants.
package cpu_pkg;

    localparam int XLEN = 32;

    // Default PC loaded at reset.
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'd128;

    // Value held in IF/ID while it carries no instruction.
    localparam logic [31:0] INS_NOP = 32'h0000_0000;

    // Fetch FSM states.
    //   FETCH : request at pc outstanding
    //   HOLD  : fetched word parked in the skid buffer, no request
    //   DRAIN : request to a stale address still outstanding after a redirect
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    // Force an address onto a 4-byte boundary.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {ins, pcp4} buffer. It holds a fetched word that arrived while
// decode was stalled, so the memory response is never lost.
module if_skid_buf #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic [31:0]     ins_i,
    input  logic [XLEN-1:0] pcp4_i,
    output logic            valid_o,
    output logic [31:0]     ins_o,
    output logic [XLEN-1:0] pcp4_o
);

    logic            valid_q;
    logic [31:0]     ins_q;
    logic [XLEN-1:0] pcp4_q;

    // Load captures a new entry; clear only drops the valid flag, and the
    // stale payload is harmless because nothing reads it without valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            ins_q   <= '0;
            pcp4_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ins_q   <= ins_i;
            pcp4_q  <= pcp4_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign ins_o   = ins_q;
    assign pcp4_o  = pcp4_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request
// in flight, and fills the IF/ID register. Redirects (interrupt or branch)
// may arrive at any time, including while a request is outstanding; the
// memory contract forbids changing a pending request, so such a request is
// drained and its data dropped.
module if_fetch_stage
    import cpu_pkg::*;
#(
    parameter int              XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            int_req,
    input  logic [XLEN-1:0] entry_point,
    input  logic            redir_valid,
    input  logic [XLEN-1:0] redir_pc,
    input  logic            id_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            ifid_valid,
    output logic [31:0]     ifid_ins,
    output logic [XLEN-1:0] ifid_pcp4
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] drain_addr_q;
    logic            ifid_valid_q;
    logic [31:0]     ifid_ins_q;
    logic [XLEN-1:0] ifid_pcp4_q;

    logic            redirect;
    logic [XLEN-1:0] target_d;
    logic [XLEN-1:0] pc_p4_d;
    logic            slot_free;
    logic            skid_load;
    logic            skid_clear;
    logic            skid_valid;
    logic [31:0]     skid_ins;
    logic [XLEN-1:0] skid_pcp4;

    // Decode redirect priority, IF/ID availability and skid-buffer control.
    always_comb begin
        redirect   = int_req | redir_valid;
        target_d   = word_align(int_req ? entry_point : redir_pc);
        pc_p4_d    = pc_q + XLEN'(4);
        slot_free  = !ifid_valid_q || id_ready;
        skid_load  = (state_q == FETCH) && imem_rvalid && !slot_free && !redirect;
        skid_clear = redirect || ((state_q == HOLD) && slot_free);
    end

    // Request is dropped while in reset so a late response cannot be mistaken
    // for a new one; during DRAIN the original address is kept on the bus.
    assign imem_req  = rst_n && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    if_skid_buf #(
        .XLEN(XLEN)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (skid_load),
        .clear_i (skid_clear),
        .ins_i   (imem_rdata),
        .pcp4_i  (pc_p4_d),
        .valid_o (skid_valid),
        .ins_o   (skid_ins),
        .pcp4_o  (skid_pcp4)
    );

    // Fetch FSM, PC and IF/ID register. A consumed IF/ID entry is invalidated
    // by default; each state then overrides with a fresh load if it has one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            ifid_valid_q <= 1'b0;
            ifid_ins_q   <= INS_NOP;
            ifid_pcp4_q  <= '0;
        end else begin
            if (slot_free) begin
                ifid_valid_q <= 1'b0;
            end
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        pc_q         <= target_d;
                        ifid_valid_q <= 1'b0;
                        if (!imem_rvalid) begin
                            // Request to the old pc is still pending.
                            state_q      <= DRAIN;
                            drain_addr_q <= pc_q;
                        end
                    end else if (imem_rvalid) begin
                        pc_q <= pc_p4_d;
                        if (slot_free) begin
                            ifid_valid_q <= 1'b1;
                            ifid_ins_q   <= imem_rdata;
                            ifid_pcp4_q  <= pc_p4_d;
                        end else begin
                            state_q <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q         <= target_d;
                        ifid_valid_q <= 1'b0;
                        state_q      <= FETCH;
                    end else if (slot_free && skid_valid) begin
                        ifid_valid_q <= 1'b1;
                        ifid_ins_q   <= skid_ins;
                        ifid_pcp4_q  <= skid_pcp4;
                        state_q      <= FETCH;
                    end
                end
                DRAIN: begin
                    if (redirect) begin
                        pc_q         <= target_d;
                        ifid_valid_q <= 1'b0;
                    end
                    if (imem_rvalid) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign ifid_valid = ifid_valid_q;
    assign ifid_ins   = ifid_ins_q;
    assign ifid_pcp4  = ifid_pcp4_q;

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Pipelined instruction-fetch stage for the 5-stage CPU. Owns the PC register and issues one instruction-memory request at a time. Delivers fetched instructions into the IF/ID pipeline register consumed by the decode stage. Handles decode back-pressure, branch/jump redirects from execute, and interrupt entry-point redirects, including redirects that arrive while a memory request is outstanding.

## Interface
- XLEN, 32, datapath/address width
- RESET_PC, 128, PC loaded at reset

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- int_req  in  1  interrupt redirect to entry_point (highest priority)
- entry_point  in  XLEN  interrupt target PC
- redir_valid  in  1  branch/jump taken redirect from EX
- redir_pc  in  XLEN  redirect target PC
- id_ready  in  1  decode accepts IF/ID contents this cycle
- imem_req  out  1  fetch request
- imem_addr  out  XLEN  fetch address (word aligned)
- imem_rvalid  in  1  response valid; may be asserted in the same cycle as imem_req (combinational memory)
- imem_rdata  in  32  instruction word
- ifid_valid  out  1  IF/ID holds a valid instruction
- ifid_ins  out  32  instruction
- ifid_pcp4  out  XLEN  PC+4 of that instruction

## Operation
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: response parked in the skid buffer; imem_req=0.
  - DRAIN: stale request outstanding; imem_req=1, imem_addr=old address.
- Slot free: `!ifid_valid || id_ready`.
- FETCH with rvalid, slot free, no redirect:
  - IF/ID <= {1, rdata, pc+4}.
  - pc <= pc+4.
  - Stay in FETCH.
- FETCH with rvalid, slot not free: skid <= {rdata, pc+4}, pc <= pc+4, go to HOLD.
- HOLD when slot frees: IF/ID <= skid, go to FETCH.
- Redirect event = int_req | redir_valid. Target is entry_point if int_req, else redir_pc.
- On a redirect event:
  - pc <= target.
  - ifid_valid <= 0.
  - Skid is discarded.
  - Any rvalid data in that cycle is discarded.
- State after a redirect:
  - DRAIN if in FETCH with no rvalid in that cycle.
  - Otherwise FETCH.
- DRAIN: on rvalid, discard the data and go to FETCH. A further redirect in DRAIN only updates pc.
- Memory contract: once imem_req is asserted, imem_req and imem_addr stay stable until rvalid.
- PC arithmetic is XLEN-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values:
  - pc=RESET_PC, state=FETCH.
  - ifid_valid=0, ifid_ins=0, ifid_pcp4=0.
  - imem_req=0 while rst_n is low.
  - imem_req=1, addr=RESET_PC in the first cycle after release.
- Latency: rvalid at edge N appears on IF/ID after edge N. With a zero-latency memory and id_ready=1, throughput is 1 instruction per cycle.
- When id_ready=0 and ifid_valid=1, IF/ID is held bit-stable.
- Redirect takes effect at the next edge: IF/ID is invalid after it. The first new-target request is issued in the following cycle, or after DRAIN completes.
- Reset asserted mid-request: state and outputs return to reset values immediately (asynchronous). Any late rvalid is ignored because imem_req=0.

## Structure
- Shared package `cpu_pkg`:
  - XLEN.
  - fetch state enum {FETCH, HOLD, DRAIN}.
  - INS_NOP = 32'h0000_0000.
  - RESET_PC default.
- Sub-module `if_skid_buf`: one-entry {ins, pcp4} buffer with load/clear; the FSM and PC stay in the top level.

## Test plan
- Reset release, zero-latency memory, id_ready=1 → addresses 128,132,136 on consecutive cycles; ifid_pcp4 = 132,136,140.
- id_ready low for 3 cycles with rvalid in the first of them:
  - IF/ID held stable.
  - One skid capture, imem_req=0 during HOLD.
  - On release, the skid instruction follows with no loss or duplicate.
- 3-cycle memory latency, redir_valid with redir_pc=0x200 in cycle 1 of an outstanding request:
  - imem_addr unchanged until rvalid.
  - That data is dropped.
  - Next request has addr 0x200.
- int_req and redir_valid in the same cycle, entry_point=0x80, redir_pc=0x300 → pc=0x80 and ifid_valid=0.
- Redirect coinciding with rvalid → data discarded; no DRAIN; next cycle addr=target.
- Full check: pc=0xFFFF_FFFC fetch → ifid_pcp4=0. rst_n low mid-request → all outputs return to reset values asynchronously.
